regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
- Shares the single write port of register_memory among three writeback sources: ALU (A), memory load (M) and multiply/divide (X, which also produces a 16-bit high result for R15).
- Holds one request per source, arbitrates round-robin, and interleaves writes with decode reads through a bounded-defer policy.
- Keeps an R15 shadow, because the register file loads R15 from write_reg_15 on every write cycle.
- Sits between the writeback sources and register_memory.

Parameters:
MAX_DEFER, 3, consecutive cycles a pending write may be deferred by reads before it is forced (range 1..15).
R15_RESET, 16'h0000, reset value of the R15 shadow; matches the register file's R15 reset value.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
a_valid  in  1  ALU write request
a_ready  out  1  ALU holding slot free
a_reg  in  4  ALU destination register
a_data  in  16  ALU write data
m_valid  in  1  load write request
m_ready  out  1  load holding slot free
m_reg  in  4  load destination register
m_data  in  16  load write data
x_valid  in  1  mul/div write request
x_ready  out  1  mul/div holding slot free
x_reg  in  4  mul/div destination register
x_data  in  16  mul/div low result
x_data15  in  16  mul/div high result, destined for R15
rd_req  in  1  decode needs the register file in read mode this cycle
rd_stall  out  1  read denied this cycle; decode must hold
pending  out  16  bit r set while any held request targets register r
rf_read_write_enable  out  1  to register_memory; 1 = read, 0 = write
rf_write_reg  out  4  to register_memory write_reg
rf_write_data  out  16  to register_memory write_data
rf_write_reg_15  out  16  to register_memory write_reg_15

Behaviour:
- Reset: all holding slots empty; *_ready = 0 while rst is high, 1 after; rd_stall = 0; pending = 0; rf_read_write_enable = 1; rf_write_reg = 0; rf_write_data = 0; R15 shadow = R15_RESET; rf_write_reg_15 = shadow; round-robin pointer = A; defer counter = 0; state = IDLE.
- Accept: a request is accepted on the clock edge where valid && ready.
  - ready = slot empty (registered; no combinational path from valid or rd_req).
  - Per-source throughput: one request every 2 cycles.
- Write timing: a write is issued in the cycle after acceptance at the earliest. The RF captures it at the end of that cycle, and the slot frees on the same edge.
- Arbitration: round-robin among occupied slots, order A -> M -> X. The pointer advances past the source just granted.
- FSM:
  - IDLE: no slot occupied. rf_read_write_enable = 1. Go to ARB on any acceptance.
  - ARB, rd_req = 0: issue grant. rf_read_write_enable = 0; rf_* driven from the granted slot; counter = 0.
  - ARB, rd_req = 1: read wins; counter++. When counter == MAX_DEFER, go to FORCE.
  - FORCE: issue grant regardless of rd_req; rd_stall = rd_req; counter = 0. Go to ARB if slots remain occupied, otherwise IDLE.
  - ARB -> IDLE when the last slot frees and no new acceptance occurs.
- rd_stall is asserted only in FORCE.
- Grant from A or M:
  - rf_write_reg = reg; rf_write_data = data.
  - rf_write_reg_15 = data if reg == 15, else shadow.
  - Shadow updated when reg == 15.
- Grant from X:
  - rf_write_reg_15 = x_data15; shadow <= x_data15.
  - If x_reg == 15: the high result wins. rf_write_reg = 15 and rf_write_data = x_data15.
  - Otherwise rf_write_reg = x_reg and rf_write_data = x_data.
- Not granting: rf_write_reg, rf_write_data and rf_write_reg_15 hold their last values.
- pending is combinational from slot contents. An X slot sets both bit x_reg and bit 15.
- Ordering of writes to the same register from different sources is not guaranteed. Decode uses pending to avoid such hazards.
- rst asserted mid-operation: held requests are discarded; no partial write occurs.

Optional Feature:
REGFILE_SCHED_STATS_EN
- Defined: adds outputs stat_a, stat_m, stat_x (16 bits each, saturating counters of granted writes per source) and stat_force (16 bits, count of FORCE cycles). All reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the source-ID encoding (A = 0, M = 1, X = 2);
  - the FSM state encoding (IDLE/ARB/FORCE);
  - REG_W = 4, DATA_W = 16, R15_IDX = 15.
- One natural sub-module: wb_hold_slot, a single-entry holding register with valid/ready, instantiated three times (X variant carries data15).

Test Plan:
- After reset, with rd_req = 0, accept A (reg 1, 16'hABCD). Next cycle: rf_read_write_enable = 0, rf_write_reg = 1, rf_write_data = 16'hABCD, rf_write_reg_15 = 16'h0000. pending[1] = 1 until that edge.
- A, M, X all accepted in the same cycle (regs 2, 3, 4), rd_req = 0 -> writes in order A, M, X on three consecutive cycles. X cycle has rf_write_reg_15 = x_data15 = 16'hAAAA.
- MAX_DEFER = 3, A pending, rd_req held at 1 -> three read cycles, then FORCE. Write issued with rd_stall = 1 for exactly one cycle.
- X with reg = 15, x_data = 16'h5879, x_data15 = 16'h1234 -> rf_write_reg = 15, rf_write_data = 16'h1234. A subsequent A write to reg 7 shows rf_write_reg_15 = 16'h1234.
- A accepted, then rst pulsed before the grant -> no write cycle; pending = 0; a_ready = 1 after rst deasserts.
- Stats (REGFILE_SCHED_STATS_EN defined): five A grants plus one FORCE -> stat_a = 5, stat_force = 1, stat_m = 0, stat_x = 0.

Source files
------------

// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types for the register-file write scheduler.
// Source IDs, FSM states, widths and round-robin helpers.
package regfile_write_scheduler_pkg;

    localparam int REG_W   = 4;
    localparam int DATA_W  = 16;
    localparam int R15_IDX = 15;

    typedef enum logic [1:0] {
        SRC_A = 2'd0,
        SRC_M = 2'd1,
        SRC_X = 2'd2
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_FORCE = 2'd2
    } state_e;

    // First occupied source at or after ptr, wrapping A -> M -> X.
    function automatic src_e rr_pick(input logic [2:0] occ,
                                     input src_e ptr);
        logic [2:0] idx;
        src_e       sel;
        sel = ptr;
        for (int i = 2; i >= 0; i--) begin
            idx = {1'b0, ptr} + 3'(i);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (occ[idx[1:0]]) sel = src_e'(idx[1:0]);
        end
        return sel;
    endfunction

    function automatic src_e next_src(input src_e s);
        case (s)
            SRC_A:   return SRC_M;
            SRC_M:   return SRC_X;
            default: return SRC_A;
        endcase
    endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// Single-entry holding register for one writeback source.
// in_valid/in_ready accept a payload; take frees the slot; occ/payload show contents.
module wb_hold_slot #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_payload,
    input  logic         take,
    output logic         occ,
    output logic [W-1:0] payload
);

    logic acc;

    assign acc = in_valid & in_ready;

    // in_ready is registered so it never depends on in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= 1'b0;
            in_ready <= 1'b0;
            payload  <= '0;
        end else begin
            if (acc) begin
                occ     <= 1'b1;
                payload <= in_payload;
            end else if (take) begin
                occ <= 1'b0;
            end
            in_ready <= !(acc || (occ && !take));
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register_memory write port among ALU, load and mul/div writebacks,
// interleaving with decode reads; optional stats under REGFILE_SCHED_STATS_EN.
module regfile_write_scheduler
    import regfile_write_scheduler_pkg::*;
#(
    parameter int          MAX_DEFER = 3,
    parameter logic [15:0] R15_RESET = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_W-1:0]  a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [REG_W-1:0]  m_reg,
    input  logic [DATA_W-1:0] m_data,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [REG_W-1:0]  x_reg,
    input  logic [DATA_W-1:0] x_data,
    input  logic [DATA_W-1:0] x_data15,
    input  logic              rd_req,
    output logic              rd_stall,
    output logic [15:0]       pending,
    output logic              rf_read_write_enable,
    output logic [REG_W-1:0]  rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [DATA_W-1:0] rf_write_reg_15
`ifdef REGFILE_SCHED_STATS_EN
    ,
    output logic [15:0]       stat_a,
    output logic [15:0]       stat_m,
    output logic [15:0]       stat_x,
    output logic [15:0]       stat_force
`endif
);

    localparam int AW = REG_W + DATA_W;
    localparam int XW = REG_W + 2 * DATA_W;
    localparam logic [3:0] MAX_D = 4'(MAX_DEFER);
    localparam logic [REG_W-1:0] R15 = REG_W'(R15_IDX);

    logic [AW-1:0] a_pl, m_pl;
    logic [XW-1:0] x_pl;
    logic [2:0]    occ, take, acc, rest_occ;

    state_e state_q, state_d;
    src_e   ptr_q, sel;
    logic [3:0] cnt_q, cnt_d;
    logic       grant;

    logic [REG_W-1:0]  reg_q, w_reg;
    logic [DATA_W-1:0] data_q, shadow_q, w_data, w15;

    logic [REG_W-1:0]  ar, mr, xr;
    logic [DATA_W-1:0] ad, md, xd, xd15;

    wb_hold_slot #(.W(AW)) u_slot_a (
        .clk(clk), .rst(rst),
        .in_valid(a_valid), .in_ready(a_ready),
        .in_payload({a_data, a_reg}),
        .take(take[0]), .occ(occ[0]), .payload(a_pl)
    );

    wb_hold_slot #(.W(AW)) u_slot_m (
        .clk(clk), .rst(rst),
        .in_valid(m_valid), .in_ready(m_ready),
        .in_payload({m_data, m_reg}),
        .take(take[1]), .occ(occ[1]), .payload(m_pl)
    );

    wb_hold_slot #(.W(XW)) u_slot_x (
        .clk(clk), .rst(rst),
        .in_valid(x_valid), .in_ready(x_ready),
        .in_payload({x_data15, x_data, x_reg}),
        .take(take[2]), .occ(occ[2]), .payload(x_pl)
    );

    assign ar   = a_pl[REG_W-1:0];
    assign ad   = a_pl[REG_W +: DATA_W];
    assign mr   = m_pl[REG_W-1:0];
    assign md   = m_pl[REG_W +: DATA_W];
    assign xr   = x_pl[REG_W-1:0];
    assign xd   = x_pl[REG_W +: DATA_W];
    assign xd15 = x_pl[AW +: DATA_W];

    assign acc = {x_valid & x_ready, m_valid & m_ready, a_valid & a_ready};

    always_comb begin
        sel      = rr_pick(occ, ptr_q);
        grant    = (|occ) &&
                   ((state_q == ST_ARB && !rd_req) || state_q == ST_FORCE);
        take     = grant ? (3'b001 << sel) : 3'b000;
        rest_occ = (occ & ~take) | acc;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|acc) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (!rd_req) begin
                    cnt_d = 4'd0;
                    if (!(|rest_occ)) state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == MAX_D) state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                cnt_d   = 4'd0;
                state_d = (|rest_occ) ? ST_ARB : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // A high result destined for R15 takes priority over the low result.
    always_comb begin
        w_reg  = ar;
        w_data = ad;
        w15    = shadow_q;
        case (sel)
            SRC_A: begin
                w_reg  = ar;
                w_data = ad;
                w15    = (ar == R15) ? ad : shadow_q;
            end
            SRC_M: begin
                w_reg  = mr;
                w_data = md;
                w15    = (mr == R15) ? md : shadow_q;
            end
            SRC_X: begin
                w15    = xd15;
                w_reg  = xr;
                w_data = (xr == R15) ? xd15 : xd;
            end
            default: ;
        endcase
    end

    always_comb begin
        pending = '0;
        if (occ[0]) pending[ar] = 1'b1;
        if (occ[1]) pending[mr] = 1'b1;
        if (occ[2]) begin
            pending[xr]      = 1'b1;
            pending[R15_IDX] = 1'b1;
        end
    end

    assign rd_stall             = (state_q == ST_FORCE) && rd_req;
    assign rf_read_write_enable = !grant;
    assign rf_write_reg         = grant ? w_reg  : reg_q;
    assign rf_write_data        = grant ? w_data : data_q;
    assign rf_write_reg_15      = grant ? w15    : shadow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            ptr_q    <= SRC_A;
            reg_q    <= '0;
            data_q   <= '0;
            shadow_q <= R15_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                ptr_q    <= next_src(sel);
                reg_q    <= w_reg;
                data_q   <= w_data;
                shadow_q <= w15;
            end
        end
    end

`ifdef REGFILE_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_a     <= '0;
            stat_m     <= '0;
            stat_x     <= '0;
            stat_force <= '0;
        end else begin
            if (take[0] && stat_a != 16'hFFFF) stat_a <= stat_a + 16'd1;
            if (take[1] && stat_m != 16'hFFFF) stat_m <= stat_m + 16'd1;
            if (take[2] && stat_x != 16'hFFFF) stat_x <= stat_x + 16'd1;
            if (state_q == ST_FORCE && stat_force != 16'hFFFF)
                stat_force <= stat_force + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed vector bench for regfile_write_scheduler.
// One vector per clock cycle; outputs compared mid-cycle.
module tb_regfile_write_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 0, m_valid = 0, x_valid = 0, rd_req = 0;
    logic [3:0]  a_reg = 0, m_reg = 0, x_reg = 0;
    logic [15:0] a_data = 0, m_data = 0, x_data = 0, x_data15 = 0;
    logic        a_ready, m_ready, x_ready, rd_stall, rwe;
    logic [15:0] pending, wdata, w15;
    logic [3:0]  wreg;
`ifdef REGFILE_SCHED_STATS_EN
    logic [15:0] stat_a, stat_m, stat_x, stat_force;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_write_scheduler #(.MAX_DEFER(3), .R15_RESET(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_reg(a_reg), .a_data(a_data),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_reg(m_reg), .m_data(m_data),
        .x_valid(x_valid), .x_ready(x_ready),
        .x_reg(x_reg), .x_data(x_data), .x_data15(x_data15),
        .rd_req(rd_req), .rd_stall(rd_stall), .pending(pending),
        .rf_read_write_enable(rwe), .rf_write_reg(wreg),
        .rf_write_data(wdata), .rf_write_reg_15(w15)
`ifdef REGFILE_SCHED_STATS_EN
        ,
        .stat_a(stat_a), .stat_m(stat_m),
        .stat_x(stat_x), .stat_force(stat_force)
`endif
    );

    typedef struct {
        logic        rst, av, mv, xv, rd;
        logic [3:0]  ar, mr, xr;
        logic [15:0] ad, md, xd, x15;
        logic        e_rwe, e_stl;
        logic [3:0]  e_wr;
        logic [15:0] e_wd, e_w15, e_pend;
        logic [2:0]  e_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, av, input logic [3:0] ar, input logic [15:0] ad,
        input logic mv, input logic [3:0] mr, input logic [15:0] md,
        input logic xv, input logic [3:0] xr, input logic [15:0] xd, x15,
        input logic rd, erwe, input logic [3:0] ewr,
        input logic [15:0] ewd, ew15, input logic estl,
        input logic [15:0] epend, input logic [2:0] erdy);
        vec_t v;
        v.rst = r;  v.av = av; v.ar = ar; v.ad = ad;
        v.mv = mv;  v.mr = mr; v.md = md;
        v.xv = xv;  v.xr = xr; v.xd = xd; v.x15 = x15;
        v.rd = rd;  v.e_rwe = erwe; v.e_wr = ewr; v.e_wd = ewd;
        v.e_w15 = ew15; v.e_stl = estl; v.e_pend = epend; v.e_rdy = erdy;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int          g_n, stalls;
    int          g_cyc[4];
    logic [3:0]  g_reg[4];

    initial begin
        //          rst a  ar  ad      m  mr md      x  xr  xd      x15     rd  rwe wr  wd      w15     st pend     rdy
        vecs.push_back(mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 1, 0,  16'h0,    16'h0,    0, 16'h0000, 3'b000));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 1, 0,  16'h0,    16'h0,    0, 16'h0000, 3'b000));
        vecs.push_back(mk(0, 1, 1, 16'hABCD, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 1, 0,  16'h0,    16'h0,    0, 16'h0000, 3'b111));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 0, 1,  16'hABCD, 16'h0,    0, 16'h0002, 3'b110));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 1, 1,  16'hABCD, 16'h0,    0, 16'h0000, 3'b111));
        vecs.push_back(mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 1, 0,  16'h0,    16'h0,    0, 16'h0000, 3'b000));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 1, 0,  16'h0,    16'h0,    0, 16'h0000, 3'b000));
        vecs.push_back(mk(0, 1, 2, 16'h1111, 1, 3, 16'h2222, 1, 4, 16'h3333, 16'hAAAA, 0, 1, 0,  16'h0,    16'h0,    0, 16'h0000, 3'b111));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 0, 2,  16'h1111, 16'h0,    0, 16'h801C, 3'b000));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 0, 3,  16'h2222, 16'h0,    0, 16'h8018, 3'b001));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 0, 4,  16'h3333, 16'hAAAA, 0, 16'h8010, 3'b011));
        vecs.push_back(mk(0, 1, 5, 16'h5555, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 1, 4,  16'h3333, 16'hAAAA, 0, 16'h0000, 3'b111));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    1, 1, 4,  16'h3333, 16'hAAAA, 0, 16'h0020, 3'b110));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    1, 1, 4,  16'h3333, 16'hAAAA, 0, 16'h0020, 3'b110));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    1, 1, 4,  16'h3333, 16'hAAAA, 0, 16'h0020, 3'b110));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    1, 0, 5,  16'h5555, 16'hAAAA, 1, 16'h0020, 3'b110));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 15,16'h5879, 16'h1234, 1, 1, 5,  16'h5555, 16'hAAAA, 0, 16'h0000, 3'b111));
        vecs.push_back(mk(0, 1, 7, 16'h7777, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 0, 15, 16'h1234, 16'h1234, 0, 16'h8000, 3'b011));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 0, 7,  16'h7777, 16'h1234, 0, 16'h0080, 3'b110));
        vecs.push_back(mk(0, 1, 15,16'hBEEF, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 1, 7,  16'h7777, 16'h1234, 0, 16'h0000, 3'b111));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 0, 15, 16'hBEEF, 16'hBEEF, 0, 16'h8000, 3'b110));
        vecs.push_back(mk(0, 1, 9, 16'h9999, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 1, 15, 16'hBEEF, 16'hBEEF, 0, 16'h0000, 3'b111));
        vecs.push_back(mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 1, 0,  16'h0,    16'h0,    0, 16'h0000, 3'b000));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 1, 0,  16'h0,    16'h0,    0, 16'h0000, 3'b000));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    0, 1, 0,  16'h0,    16'h0,    0, 16'h0000, 3'b111));

        foreach (vecs[i]) begin
            tick();
            rst     = vecs[i].rst;
            a_valid = vecs[i].av; a_reg = vecs[i].ar; a_data = vecs[i].ad;
            m_valid = vecs[i].mv; m_reg = vecs[i].mr; m_data = vecs[i].md;
            x_valid = vecs[i].xv; x_reg = vecs[i].xr; x_data = vecs[i].xd;
            x_data15 = vecs[i].x15;
            rd_req  = vecs[i].rd;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  64'({rwe, rd_stall, wreg, wdata, w15, pending,
                       x_ready, m_ready, a_ready}),
                  64'({vecs[i].e_rwe, vecs[i].e_stl, vecs[i].e_wr,
                       vecs[i].e_wd, vecs[i].e_w15, vecs[i].e_pend,
                       vecs[i].e_rdy}));
        end

        // Two held requests under a continuous read stream: each is forced
        // after three deferred cycles, and the counter restarts in between.
        tick(); a_valid = 0; rst = 1;
        tick(); rst = 0;
        tick();
        tick();
        a_valid = 1; a_reg = 4'd1; a_data = 16'h0101;
        m_valid = 1; m_reg = 4'd2; m_data = 16'h0202;
        rd_req  = 1;
        tick();
        a_valid = 0; m_valid = 0;
        g_n = 0; stalls = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!rwe && g_n < 4) begin
                g_cyc[g_n] = k;
                g_reg[g_n] = wreg;
                g_n++;
            end
            if (rd_stall) stalls++;
            tick();
        end
        rd_req = 0;
        check("force_count", 64'(g_n), 64'd2);
        check("force_first", 64'({g_cyc[0][7:0], g_reg[0]}), 64'({8'd4, 4'd1}));
        check("force_second", 64'({g_cyc[1][7:0], g_reg[1]}), 64'({8'd8, 4'd2}));
        check("stall_cycles", 64'(stalls), 64'd2);

`ifdef REGFILE_SCHED_STATS_EN
        rst = 1;
        tick(); rst = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            a_valid = 1; a_reg = 4'(i + 1); a_data = 16'(i);
            rd_req  = (i == 4);
            tick();
            a_valid = 0;
            repeat (5) tick();
            rd_req = 0;
        end
        @(negedge clk);
        check("stats", 64'({stat_a, stat_m, stat_x, stat_force}),
              64'({16'd5, 16'd0, 16'd0, 16'd1}));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
